// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the ALU and load result channels onto the single
// register-file write port. Each channel owns one holding entry. When both
// entries hold a result, the grant alternates between them. The block also
// answers hazard queries for pending writes and counts the writes it issues.
// Optional feature: define WB_BYPASS_EN to add the byp1_*/byp2_* forwarding outputs.
module writeback_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            WE3,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD3,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  output logic            busy1,
  output logic            busy2,
  output logic [15:0]     wb_count
`ifdef WB_BYPASS_EN
  ,
  output logic            byp1_valid,
  output logic [XLEN-1:0] byp1_data,
  output logic            byp2_valid,
  output logic [XLEN-1:0] byp2_data
`endif
);

  logic            alu_v_q, alu_v_d;
  logic [4:0]      alu_rd_q, alu_rd_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d;
  logic            ld_v_q, ld_v_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            last_q, last_d;  // 0: ALU granted last, 1: load granted last
  logic [15:0]     cnt_q, cnt_d;

  logic grant_alu, grant_ld;
  logic alu_xfer, ld_xfer;
  logic hit1_alu, hit1_ld, hit2_alu, hit2_ld;

  // Grant selection, handshake readiness and the register-file write port.
  always_comb begin
    grant_alu = alu_v_q & (~ld_v_q | last_q);
    grant_ld  = ld_v_q & ~grant_alu;
    alu_ready = ~alu_v_q | grant_alu;
    ld_ready  = ~ld_v_q | grant_ld;
    alu_xfer  = alu_valid & alu_ready;
    ld_xfer   = ld_valid & ld_ready;
    WE3       = grant_alu | grant_ld;
    A3        = '0;
    WD3       = '0;
    if (grant_alu) begin
      A3  = alu_rd_q;
      WD3 = alu_data_q;
    end else if (grant_ld) begin
      A3  = ld_rd_q;
      WD3 = ld_data_q;
    end
  end

  // Entry reload/clear, grant history and write counter next state.
  always_comb begin
    alu_v_d    = alu_v_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    ld_v_d     = ld_v_q;
    ld_rd_d    = ld_rd_q;
    ld_data_d  = ld_data_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    // A transfer to x0 completes the handshake but leaves the entry empty.
    if (alu_xfer) begin
      alu_v_d    = (alu_rd != 5'd0);
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end else if (grant_alu) begin
      alu_v_d = 1'b0;
    end
    if (ld_xfer) begin
      ld_v_d    = (ld_rd != 5'd0);
      ld_rd_d   = ld_rd;
      ld_data_d = ld_data;
    end else if (grant_ld) begin
      ld_v_d = 1'b0;
    end
    if (WE3) begin
      last_d = grant_ld;
      cnt_d  = cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_v_q    <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      ld_v_q     <= 1'b0;
      ld_rd_q    <= '0;
      ld_data_q  <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      alu_v_q    <= alu_v_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      ld_v_q     <= ld_v_d;
      ld_rd_q    <= ld_rd_d;
      ld_data_q  <= ld_data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  // Hazard query: x0 never reports a pending write.
  always_comb begin
    hit1_alu = (A1 != 5'd0) & alu_v_q & (alu_rd_q == A1);
    hit1_ld  = (A1 != 5'd0) & ld_v_q & (ld_rd_q == A1);
    hit2_alu = (A2 != 5'd0) & alu_v_q & (alu_rd_q == A2);
    hit2_ld  = (A2 != 5'd0) & ld_v_q & (ld_rd_q == A2);
    busy1    = hit1_alu | hit1_ld;
    busy2    = hit2_alu | hit2_ld;
    wb_count = cnt_q;
  end

`ifdef WB_BYPASS_EN
  // Forward only when exactly one entry matches; a double match is ambiguous.
  always_comb begin
    byp1_valid = hit1_alu ^ hit1_ld;
    byp2_valid = hit2_alu ^ hit2_ld;
    byp1_data  = '0;
    byp2_data  = '0;
    if (hit1_alu & ~hit1_ld) byp1_data = alu_data_q;
    if (hit1_ld & ~hit1_alu) byp1_data = ld_data_q;
    if (hit2_alu & ~hit2_ld) byp2_data = alu_data_q;
    if (hit2_ld & ~hit2_alu) byp2_data = ld_data_q;
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, contention and reset
// sequences, then randomized traffic against a behavioural model.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, ld_valid;
  logic [4:0]  alu_rd, ld_rd, A1, A2, A3;
  logic [31:0] alu_data, ld_data, WD3;
  logic        alu_ready, ld_ready, WE3, busy1, busy2;
  logic [15:0] wb_count;
`ifdef WB_BYPASS_EN
  logic        byp1_valid, byp2_valid;
  logic [31:0] byp1_data, byp2_data;
`endif

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .A1        (A1),
    .A2        (A2),
    .busy1     (busy1),
    .busy2     (busy2),
    .wb_count  (wb_count)
`ifdef WB_BYPASS_EN
    ,
    .byp1_valid(byp1_valid),
    .byp1_data (byp1_data),
    .byp2_valid(byp2_valid),
    .byp2_data (byp2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    A1 = '0; A2 = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        ar;
    logic        lr;
    logic        b1;
    logic        b2;
    logic [15:0] cnt;
    logic        p1v;
    logic [31:0] p1d;
  } vec_t;

  vec_t vecs[10];

  // Behavioural model: index 0 = ALU channel, 1 = load channel.
  logic        m_v[2];
  logic [4:0]  m_rd[2];
  logic [31:0] m_d[2];
  int          m_last;
  logic [15:0] m_cnt;

  function automatic int m_grant();
    if (m_v[0] && m_v[1]) return 1 - m_last;
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic int m_matches(input logic [4:0] a);
    int n = 0;
    if (a == 5'd0) return 0;
    for (int c = 0; c < 2; c++) if (m_v[c] && m_rd[c] == a) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_byp_data(input logic [4:0] a);
    if (m_matches(a) != 1) return 32'h0;
    for (int c = 0; c < 2; c++) if (m_v[c] && m_rd[c] == a) return m_d[c];
    return 32'h0;
  endfunction

  initial begin
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    logic        in_v[2];
    logic [4:0]  in_rd[2];
    logic [31:0] in_d[2];
    logic        rdy[2];
    int          g;

    vecs[0] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                1'b1, 5'd5, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 32'h12345678};
    vecs[2] = '{1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd4, 32'hBBBB0004, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4,
                1'b1, 5'd4, 32'hBBBB0004, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 32'hAAAA0003};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3,
                1'b1, 5'd3, 32'hAAAA0003, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE0007, 5'd7, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                1'b1, 5'd7, 32'hCAFE0007, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 1'b1, 32'hCAFE0007};
    vecs[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 32'h0};

    // Reset state, observed while rst is held low.
    idle_inputs();
    A1 = 5'd0; A2 = 5'd0;
    rst = 1'b0;
    tick();
    tick();
    chk("rst WE3", {31'd0, WE3}, 32'd0);
    chk("rst A3", {27'd0, A3}, 32'd0);
    chk("rst WD3", WD3, 32'd0);
    chk("rst alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst busy", {30'd0, busy1, busy2}, 32'd0);
    chk("rst wb_count", {16'd0, wb_count}, 32'd0);
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      ld_valid  = vecs[i].lv; ld_rd  = vecs[i].lrd; ld_data  = vecs[i].ldd;
      A1 = vecs[i].a1; A2 = vecs[i].a2;
      #2;
      chk($sformatf("vec%0d WE3", i), {31'd0, WE3}, {31'd0, vecs[i].we});
      chk($sformatf("vec%0d A3", i), {27'd0, A3}, {27'd0, vecs[i].a3});
      chk($sformatf("vec%0d WD3", i), WD3, vecs[i].wd);
      chk($sformatf("vec%0d alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].ar});
      chk($sformatf("vec%0d ld_ready", i), {31'd0, ld_ready}, {31'd0, vecs[i].lr});
      chk($sformatf("vec%0d busy1", i), {31'd0, busy1}, {31'd0, vecs[i].b1});
      chk($sformatf("vec%0d busy2", i), {31'd0, busy2}, {31'd0, vecs[i].b2});
      chk($sformatf("vec%0d wb_count", i), {16'd0, wb_count}, {16'd0, vecs[i].cnt});
`ifdef WB_BYPASS_EN
      chk($sformatf("vec%0d byp1_valid", i), {31'd0, byp1_valid}, {31'd0, vecs[i].p1v});
      chk($sformatf("vec%0d byp1_data", i), byp1_data, vecs[i].p1d);
`endif
      tick();
    end

    // Sustained contention: grants alternate, load first after reset.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000A003;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h0000B004;
    #2;
    chk("cont first WE3", {31'd0, WE3}, 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("cont%0d WE3", i), {31'd0, WE3}, 32'd1);
      chk($sformatf("cont%0d A3", i), {27'd0, A3}, (i % 2 == 0) ? 32'd4 : 32'd3);
      chk($sformatf("cont%0d alu_ready", i), {31'd0, alu_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("cont%0d ld_ready", i), {31'd0, ld_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    chk("cont wb_count", {16'd0, wb_count}, 32'd8);

    // Mid-cycle reset with both entries full: nothing of them is ever written.
    A1 = 5'd3;
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("midrst WE3", {31'd0, WE3}, 32'd0);
    chk("midrst wb_count", {16'd0, wb_count}, 32'd0);
    chk("midrst busy1", {31'd0, busy1}, 32'd0);
    chk("midrst readies", {30'd0, alu_ready, ld_ready}, 32'd3);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("postrst%0d WE3", i), {31'd0, WE3}, 32'd0);
      tick();
    end
    chk("postrst wb_count", {16'd0, wb_count}, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      m_v[c] = 1'b0; m_rd[c] = '0; m_d[c] = '0;
    end
    m_last = 0;
    m_cnt  = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        in_v[c]  = ($urandom_range(0, 9) < 6);
        in_rd[c] = 5'($urandom_range(0, 7));
        in_d[c]  = $urandom;
      end
      alu_valid = in_v[0]; alu_rd = in_rd[0]; alu_data = in_d[0];
      ld_valid  = in_v[1]; ld_rd  = in_rd[1]; ld_data  = in_d[1];
      A1 = 5'($urandom_range(0, 7));
      A2 = 5'($urandom_range(0, 7));
      #2;
      g = m_grant();
      exp_a3 = (g >= 0) ? m_rd[g] : 5'd0;
      exp_wd = (g >= 0) ? m_d[g] : 32'd0;
      for (int c = 0; c < 2; c++) rdy[c] = !m_v[c] || (g == c);
      chk("rnd WE3", {31'd0, WE3}, (g >= 0) ? 32'd1 : 32'd0);
      chk("rnd A3", {27'd0, A3}, {27'd0, exp_a3});
      chk("rnd WD3", WD3, exp_wd);
      chk("rnd alu_ready", {31'd0, alu_ready}, {31'd0, rdy[0]});
      chk("rnd ld_ready", {31'd0, ld_ready}, {31'd0, rdy[1]});
      chk("rnd busy1", {31'd0, busy1}, (m_matches(A1) > 0) ? 32'd1 : 32'd0);
      chk("rnd busy2", {31'd0, busy2}, (m_matches(A2) > 0) ? 32'd1 : 32'd0);
      chk("rnd wb_count", {16'd0, wb_count}, {16'd0, m_cnt});
`ifdef WB_BYPASS_EN
      chk("rnd byp1_valid", {31'd0, byp1_valid}, (m_matches(A1) == 1) ? 32'd1 : 32'd0);
      chk("rnd byp1_data", byp1_data, m_byp_data(A1));
      chk("rnd byp2_valid", {31'd0, byp2_valid}, (m_matches(A2) == 1) ? 32'd1 : 32'd0);
      chk("rnd byp2_data", byp2_data, m_byp_data(A2));
`endif
      // Advance the model across the edge.
      if (g >= 0) begin
        m_cnt  = m_cnt + 16'd1;
        m_last = g;
      end
      for (int c = 0; c < 2; c++) begin
        if (in_v[c] && rdy[c]) begin
          m_v[c]  = (in_rd[c] != 5'd0);
          m_rd[c] = in_rd[c];
          m_d[c]  = in_d[c];
        end else if (g == c) begin
          m_v[c] = 1'b0;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width of every result and write-data path.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports alu_valid (in, 1), alu_rd (in, 5) and alu_data (in, XLEN): the ALU result channel.
REQ-005 The block SHALL have port alu_ready, output, 1 bit: the ALU channel handshake ready.
REQ-006 The block SHALL have ports ld_valid (in, 1), ld_rd (in, 5) and ld_data (in, XLEN): the load result channel.
REQ-007 The block SHALL have port ld_ready, output, 1 bit: the load channel handshake ready.
REQ-008 The block SHALL have ports WE3 (out, 1), A3 (out, 5) and WD3 (out, XLEN): the register-file write port, sampled by the register file at the same clk edge.
REQ-009 The block SHALL have ports A1 and A2 (in, 5): hazard-query addresses, mirroring the register-file read addresses.
REQ-010 The block SHALL have ports busy1 and busy2 (out, 1): the queried register has a pending write.
REQ-011 The block SHALL have port wb_count, output, 16 bits: the number of register-file writes issued.

Function
REQ-012 Each channel SHALL own one holding entry holding {valid, rd, data}; a transfer occurs at a rising edge when valid and ready are both 1.
REQ-013 ready for a channel SHALL be 1 when its entry is empty or is granted in the current cycle, giving full throughput.
REQ-014 A transfer with rd=0 SHALL complete the handshake, be discarded, and never set the entry valid.
REQ-015 Each cycle at most one valid entry SHALL be granted; WE3=1, A3=entry.rd and WD3=entry.data SHALL be driven combinationally from the granted entry, and WE3=0 when no entry is valid.
REQ-016 Arbitration: one valid entry is granted directly; when both are valid, the one not granted last (last_grant bit) is granted; last_grant SHALL update on every grant.
REQ-017 A granted entry SHALL be cleared at the edge, or reloaded if its channel transfers at the same edge.
REQ-018 Latency: data accepted at edge N SHALL appear on WE3/A3/WD3 in cycle N+1 if uncontended and is written at edge N+1; contended worst case is N+2.
REQ-019 busyX SHALL be 1 when AX!=0 and AX equals rd of any valid entry; AX=0 SHALL always give busyX=0.
REQ-020 wb_count SHALL increment by 1 on every edge with WE3=1 and wrap from 16'hFFFF to 0.

Reset
REQ-021 While rst=0, both entries SHALL be invalid, last_grant=0 (ALU), and wb_count=0; consequently WE3=0, A3=0, WD3=0, busy1=busy2=0, and alu_ready=ld_ready=1.
REQ-022 Reset asserted mid-operation SHALL discard pending entries with no register-file write issued for them.

Configuration
REQ-023 With macro WB_BYPASS_EN defined, outputs byp1_valid/byp2_valid (1) and byp1_data/byp2_data (XLEN) SHALL exist; bypX_valid=1 with the entry data when exactly one valid entry matches a non-zero AX, and bypX_valid=0 with data 0 when none or both entries match.
REQ-024 Without WB_BYPASS_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 After reset, alu transfer rd=5, data=0x12345678 -> next cycle WE3=1, A3=5, WD3=0x12345678; wb_count=1 after the edge.
REQ-026 Both channels transfer in the same cycle (alu rd=3, ld rd=4) from reset -> load is written first (A3=4), then alu (A3=3); ld_ready stays 1 and alu_ready stays 0 for one cycle.
REQ-027 Transfer with rd=0, data=0xDEADBEEF -> ready=1, WE3 stays 0, and wb_count is unchanged.
REQ-028 Pending entry rd=7 with A1=7 and A2=0 -> busy1=1 and busy2=0; with WB_BYPASS_EN, byp1_valid=1 and byp1_data equals the entry data.
REQ-029 Sustained contention from both channels for 8 cycles -> grants strictly alternate, and wb_count=8 when wb_count starts at 0.
REQ-030 rst driven low with both entries full -> WE3=0 immediately, and no write occurs after rst returns high.
